alu_issue_ctrl: RTL

- Initiator side of the add/sub execution handshake: accepts an arithmetic micro-op (opcode, two 8-bit operands) from the decode stage over valid/ready.
- Drives the ALU control code and operands, then waits for the ALU's done strobe and captures the sum and carry.
- Returns the result, carry, zero and error flags to writeback over a valid/ready response channel.
- Sits between instruction decode and the add/sub unit in the 8-bit processor datapath.

---
 rtl/alu_issue_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Initiator side of the add/sub execution handshake in the 8-bit datapath.
// Takes one arithmetic micro-op at a time from decode, drives the add/sub
// unit, waits for a fresh rising edge of its done strobe, and returns the
// captured result to writeback over a valid/ready response channel.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       micro-op handshake from decode
//   in_op, in_a, in_b       opcode and 8-bit operands
//   alu_ctrl, alu_a, alu_b  control code and operands to the add/sub unit
//   alu_done                result strobe from the ALU (may stay high)
//   alu_sum, alu_cout       ALU result and carry out
//   out_valid/out_ready     response handshake to writeback
//   out_result, out_carry   captured result and carry (sub: 1 = no borrow)
//   out_zero, out_err       result-is-zero, illegal opcode or timeout
//   busy                    an op is in flight or its response is pending
//
// Parameters
//   TIMEOUT    WAIT cycles allowed without a done rise before aborting
//   IDLE_CODE  control code driven to the ALU when no op is in flight
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [3:0]  IDLE_CODE = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [3:0] alu_ctrl,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic       alu_done,
  input  logic [7:0] alu_sum,
  input  logic       alu_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       out_carry,
  output logic       out_zero,
  output logic       out_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Wide enough to hold the value TIMEOUT itself.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  // Opcode decode: three add codes and three subtract codes; the ALU decodes
  // add versus subtract itself, so only legality matters here.
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0010, 4'b0101, 4'b0111,
      4'b0011, 4'b0110, 4'b1001: is_legal = 1'b1;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done_q;
  logic [3:0]       r_alu_ctrl;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic             r_out_valid;
  logic [7:0]       r_out_result;
  logic             r_out_carry;
  logic             r_out_zero;
  logic             r_out_err;

  logic             w_accept;
  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_timeout;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  // Only a fresh 0->1 transition counts, so a done level left high by the
  // previous op cannot complete the next one.
  assign w_rise     = alu_done & ~r_done_q;
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT));

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_done_q     <= 1'b0;
      r_alu_ctrl   <= IDLE_CODE;
      r_alu_a      <= 8'h00;
      r_alu_b      <= 8'h00;
      r_out_valid  <= 1'b0;
      r_out_result <= 8'h00;
      r_out_carry  <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_err    <= 1'b0;
    end else begin
      // Edge detector history runs in every state.
      r_done_q <= alu_done;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (is_legal(in_op)) begin
              r_alu_ctrl <= in_op;
              r_alu_a    <= in_a;
              r_alu_b    <= in_b;
              r_cnt      <= '0;
              r_state    <= S_WAIT;
            end else begin
              // Illegal opcode: answer with an error without touching the ALU.
              r_out_result <= 8'h00;
              r_out_carry  <= 1'b0;
              r_out_zero   <= 1'b0;
              r_out_err    <= 1'b1;
              r_out_valid  <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          r_cnt <= w_cnt_next;
          // A rise takes priority over a timeout landing in the same cycle.
          if (w_rise) begin
            r_out_result <= alu_sum;
            r_out_carry  <= alu_cout;
            r_out_zero   <= (alu_sum == 8'h00);
            r_out_err    <= 1'b0;
            r_out_valid  <= 1'b1;
            r_alu_ctrl   <= IDLE_CODE;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_out_result <= 8'h00;
            r_out_carry  <= 1'b0;
            r_out_zero   <= 1'b0;
            r_out_err    <= 1'b1;
            r_out_valid  <= 1'b1;
            r_alu_ctrl   <= IDLE_CODE;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          // Response fields hold until writeback takes them.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_alu_ctrl  <= IDLE_CODE;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake status decodes the state directly.
  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);

  assign alu_ctrl   = r_alu_ctrl;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_zero   = r_out_zero;
  assign out_err    = r_out_err;

endmodule
